// File: rtl/mem_stage.sv
// Memory stage: req/ack data-memory access with lane steering and load extension.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [XLEN-1:0] rd_in,
    input  logic            writeback_en_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic [1:0]      mem_size_in,
    input  logic            mem_unsigned_in,
    input  logic [XLEN-1:0] store_data_in,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            valid_out,
    output logic [4:0]      rd_addr_out,
    output logic [XLEN-1:0] rd_out,
    output logic            writeback_en_out,
    output logic            misalign_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            ld_q, ld_d;
    logic [4:0]      rda_q, rda_d;
    logic            wb_q, wb_d;
    logic            vout_q, vout_d;
    logic [4:0]      rdao_q, rdao_d;
    logic [XLEN-1:0] rdo_q, rdo_d;
    logic            wbo_q, wbo_d;

    logic            is_mem;
    logic            trap;
    logic            start;
    logic            in_wait;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;

    assign is_mem  = valid_in & (mem_read_in | mem_write_in);
    assign in_wait = (state_q == S_WAIT);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap = is_mem &
                  (((mem_size_in == 2'b01) & rd_in[0]) |
                   (mem_size_in[1] & (|rd_in[1:0])));
    assign misalign_out = mis_q;
`else
    assign trap = 1'b0;
    assign misalign_out = 1'b0;
`endif

    assign start     = (state_q == S_IDLE) & is_mem & ~trap;
    assign stall_out = start | (in_wait & ~dmem_ack);

    // Store data is replicated across lanes; strobes pick the live bytes.
    always_comb begin
        st_wdata = store_data_in;
        st_wstrb = 4'b1111;
        unique case (1'b1)
            (mem_size_in == 2'b00): begin
                st_wdata = {4{store_data_in[7:0]}};
                st_wstrb = 4'b0001 << rd_in[1:0];
            end
            (mem_size_in == 2'b01): begin
                st_wdata = {2{store_data_in[15:0]}};
                st_wstrb = rd_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = store_data_in;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        unique case (ea_q[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ea_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_val  = dmem_rdata;
        unique case (1'b1)
            (size_q == 2'b00):
                ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            (size_q == 2'b01):
                ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
            default:
                ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ea_d    = ea_q;
        size_d  = size_q;
        uns_d   = uns_q;
        ld_d    = ld_q;
        rda_d   = rda_q;
        wb_d    = wb_q;
        vout_d  = 1'b0;
        rdao_d  = '0;
        rdo_d   = '0;
        wbo_d   = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_write_in & ~mem_read_in;
                    addr_d  = {rd_in[XLEN-1:2], 2'b00};
                    wdata_d = st_wdata;
                    wstrb_d = st_wstrb;
                    ea_d    = rd_in;
                    size_d  = mem_size_in;
                    uns_d   = mem_unsigned_in;
                    ld_d    = mem_read_in;
                    rda_d   = rd_addr_in;
                    wb_d    = writeback_en_in;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                end else if (trap) begin
                    vout_d  = 1'b1;
                    rdao_d  = rd_addr_in;
                    rdo_d   = rd_in;
                    mis_d   = 1'b1;
`endif
                end else if (valid_in) begin
                    vout_d  = 1'b1;
                    rdao_d  = rd_addr_in;
                    rdo_d   = rd_in;
                    wbo_d   = writeback_en_in;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    vout_d  = 1'b1;
                    rdao_d  = rda_q;
                    rdo_d   = ld_q ? ld_val : ea_q;
                    wbo_d   = ld_q & wb_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ea_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            ld_q    <= 1'b0;
            rda_q   <= '0;
            wb_q    <= 1'b0;
            vout_q  <= 1'b0;
            rdao_q  <= '0;
            rdo_q   <= '0;
            wbo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ea_q    <= ea_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            ld_q    <= ld_d;
            rda_q   <= rda_d;
            wb_q    <= wb_d;
            vout_q  <= vout_d;
            rdao_q  <= rdao_d;
            rdo_q   <= rdo_d;
            wbo_q   <= wbo_d;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`endif

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_wstrb       = wstrb_q;
    assign valid_out        = vout_q;
    assign rd_addr_out      = rdao_q;
    assign rd_out           = rdo_q;
    assign writeback_en_out = wbo_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; M/WB results are checked against a queue
// of expected entries pushed as each instruction is driven.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [4:0]  rd_addr_in = '0;
    logic [31:0] rd_in = '0;
    logic        writeback_en_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [1:0]  mem_size_in = '0;
    logic        mem_unsigned_in = 1'b0;
    logic [31:0] store_data_in = '0;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        valid_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_out;
    logic        writeback_en_out;
    logic        misalign_out;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .rd_addr_in       (rd_addr_in),
        .rd_in            (rd_in),
        .writeback_en_in  (writeback_en_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .mem_size_in      (mem_size_in),
        .mem_unsigned_in  (mem_unsigned_in),
        .store_data_in    (store_data_in),
        .stall_out        (stall_out),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .valid_out        (valid_out),
        .rd_addr_out      (rd_addr_out),
        .rd_out           (rd_out),
        .writeback_en_out (writeback_en_out),
        .misalign_out     (misalign_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        wb;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_vout = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Every M/WB valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!rst && valid_out) begin
            got = {rd_addr_out, rd_out, writeback_en_out, misalign_out};
            n_vout++;
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_valid obs=%h exp=none", got);
            end else begin
                e = q.pop_front();
                assert (got === e) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL mwb obs=%h exp=%h", got, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    task automatic op(input logic [4:0] a, input logic [31:0] d,
                      input logic wb, input logic rd, input logic wr,
                      input logic [1:0] sz, input logic u,
                      input logic [31:0] sd);
        valid_in        = 1'b1;
        rd_addr_in      = a;
        rd_in           = d;
        writeback_en_in = wb;
        mem_read_in     = rd;
        mem_write_in    = wr;
        mem_size_in     = sz;
        mem_unsigned_in = u;
        store_data_in   = sd;
    endtask

    // Run one memory op already on the inputs: n_wait stalled WAIT cycles, then ack.
    task automatic mem_txn(input string tag, input int n_wait,
                           input logic [31:0] rdata, input exp_t e,
                           input logic [31:0] ea, input logic we,
                           input logic [31:0] wd, input logic [3:0] ws);
        #1;
        chk({tag, "_stall_idle"}, stall_out, 1);
        step();
        for (int i = 0; i <= n_wait; i++) begin
            chk({tag, "_req"}, dmem_req, 1);
            chk({tag, "_addr"}, dmem_addr, ea);
            chk({tag, "_we"}, dmem_we, we);
            if (we) begin
                chk({tag, "_wdata"}, dmem_wdata, wd);
                chk({tag, "_wstrb"}, dmem_wstrb, ws);
            end
            if (i < n_wait) begin
                chk({tag, "_stall_wait"}, stall_out, 1);
                step();
            end
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        q.push_back(e);
        #1;
        chk({tag, "_stall_ack"}, stall_out, 0);
        step();
        dmem_ack = 1'b0;
        idle();
        #1;
        chk({tag, "_req_drop"}, dmem_req, 0);
        step();
    endtask

    initial begin
        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_wstrb", dmem_wstrb, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_mis", misalign_out, 0);
        step();
        rst = 1'b0;
        step();

        op(5'd5, 32'h1234, 1, 0, 0, 2'b10, 0, 0);
        #1;
        chk("pt_stall", stall_out, 0);
        q.push_back('{5'd5, 32'h1234, 1'b1, 1'b0});
        step();
        idle();
        chk("pt_valid", valid_out, 1);
        #1;
        chk("pt_stall2", stall_out, 0);
        step();
        chk("pt_bubble", valid_out, 0);

        op(5'd7, 32'h103, 1, 1, 0, 2'b00, 0, 0);
        mem_txn("lb", 3, 32'h80FF_0000, '{5'd7, 32'hFFFF_FF80, 1'b1, 1'b0},
                32'h100, 0, 0, 0);
        op(5'd8, 32'h103, 1, 1, 0, 2'b00, 1, 0);
        mem_txn("lbu", 3, 32'h80FF_0000, '{5'd8, 32'h0000_0080, 1'b1, 1'b0},
                32'h100, 0, 0, 0);

        op(5'd3, 32'h22, 1, 0, 1, 2'b01, 0, 32'hABCD_1234);
        mem_txn("sh", 1, 32'h0, '{5'd3, 32'h22, 1'b0, 1'b0},
                32'h20, 1, 32'h1234_1234, 4'b1100);
        op(5'd4, 32'h41, 1, 0, 1, 2'b00, 0, 32'h0000_005A);
        mem_txn("sb", 0, 32'h0, '{5'd4, 32'h41, 1'b0, 1'b0},
                32'h40, 1, 32'h5A5A_5A5A, 4'b0010);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        op(5'd6, 32'h201, 1, 1, 0, 2'b10, 0, 0);
        #1;
        chk("mis_stall", stall_out, 0);
        q.push_back('{5'd6, 32'h201, 1'b0, 1'b1});
        step();
        idle();
        chk("mis_req", dmem_req, 0);
        chk("mis_pulse", misalign_out, 1);
        step();
        chk("mis_pulse_end", misalign_out, 0);
`else
        op(5'd6, 32'h201, 1, 1, 0, 2'b10, 0, 0);
        mem_txn("lw_mis", 0, 32'h1122_3344, '{5'd6, 32'h1122_3344, 1'b1, 1'b0},
                32'h200, 0, 0, 0);
        chk("mis_tied", misalign_out, 0);
`endif

        op(5'd9, 32'h300, 1, 1, 0, 2'b10, 0, 0);
        #1;
        chk("b2b_stall1", stall_out, 1);
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8001_BEEF;
        q.push_back('{5'd9, 32'h8001_BEEF, 1'b1, 1'b0});
        #1;
        chk("b2b_stall_ack1", stall_out, 0);
        step();
        dmem_ack = 1'b0;
        op(5'd10, 32'h302, 1, 1, 0, 2'b01, 0, 0);
        #1;
        chk("b2b_stall2", stall_out, 1);
        step();
        chk("b2b_wait2_valid", valid_out, 0);
        dmem_ack = 1'b1;
        q.push_back('{5'd10, 32'hFFFF_8001, 1'b1, 1'b0});
        #1;
        chk("b2b_stall_ack2", stall_out, 0);
        step();
        dmem_ack = 1'b0;
        op(5'd11, 32'h55, 1, 0, 0, 2'b10, 0, 0);
        q.push_back('{5'd11, 32'h55, 1'b1, 1'b0});
        #1;
        chk("b2b_alu_stall", stall_out, 0);
        chk("b2b_ld2_rd", rd_addr_out, 10);
        step();
        idle();
        chk("b2b_alu_rd", rd_addr_out, 11);
        step();

        op(5'd12, 32'h400, 1, 1, 0, 2'b10, 0, 0);
        step();
        chk("rw_req_pre", dmem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_wstrb", dmem_wstrb, 0);
        chk("rw_valid", valid_out, 0);
        chk("rw_rd_out", rd_out, 0);
        idle();
        step();
        rst = 1'b0;
        dmem_ack = 1'b1;
        step();
        step();
        chk("rw_ack_ign_req", dmem_req, 0);
        chk("rw_ack_ign_stall", stall_out, 0);
        dmem_ack = 1'b0;
        step();
        step();

        chk("sb_empty", q.size(), 0);
        chk("vout_count", n_vout, 9);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the pipelined RISC-V core. Consumes the EX/M register outputs (destination address, ALU result, writeback enable) plus the load/store controls.
- Performs loads and stores over a req/ack data-memory port, with byte-lane steering and sign/zero extension.
- Drives the M/WB fields and a stall back to the upstream stages.
- Non-memory instructions pass through with 1-cycle registered latency.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_in  in  1  EX/M slot holds an instruction
- rd_addr_in  in  5  destination register
- rd_in  in  32  ALU result; the effective address for memory ops
- writeback_en_in  in  1  instruction writes rd
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- mem_size_in  in  2  00 byte, 01 half, 10/11 word
- mem_unsigned_in  in  1  zero-extend loads
- store_data_in  in  32  rs2 value for stores
- stall_out  out  1  upstream must hold its EX/M outputs
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  request complete; rdata valid on loads
- dmem_rdata  in  32  load word
- valid_out  out  1  M/WB slot valid
- rd_addr_out  out  5  to WB
- rd_out  out  32  to WB
- writeback_en_out  out  1  to WB
- misalign_out  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset (async, takes effect immediately): FSM=IDLE. dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata all 0. valid_out, rd_addr_out, rd_out, writeback_en_out, misalign_out all 0. A request in flight is abandoned; an ack after reset release is ignored.
- FSM states: IDLE, WAIT.
- IDLE, valid_in=0: next cycle valid_out=0, writeback_en_out=0, rd_addr_out=0, rd_out=0 (bubble).
- IDLE, valid_in=1, no memory op: outputs register the inputs next cycle (valid_out=1). No stall.
- IDLE, valid_in=1 with mem_read_in or mem_write_in:
  - Latch address, size, signedness, store data and rd_addr.
  - Next cycle: dmem_req=1; dmem_addr={rd_in[31:2],2'b00}; dmem_we=mem_write_in; wdata/wstrb steered as below.
  - Go to WAIT. valid_out=0 for that cycle.
- WAIT:
  - dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_wstrb stay stable until dmem_ack=1 is sampled.
  - On ack: dmem_req←0; valid_out←1; rd_addr_out←latched rd_addr; go to IDLE.
  - Load on ack: rd_out←extended lane; writeback_en_out←latched writeback_en.
  - Store on ack: rd_out←address; writeback_en_out←0.
- stall_out (combinational) = (IDLE & valid_in & (mem_read_in|mem_write_in)) | (WAIT & ~dmem_ack). It drops in the ack cycle so upstream advances the same edge.
- dmem_ack is ignored while dmem_req=0.
- mem_read_in and mem_write_in both high: treated as a load.
- Store steering (k=addr[1:0]):
  - byte: wdata={4{sd[7:0]}}, wstrb=4'b0001<<k
  - half: wdata={2{sd[15:0]}}, wstrb=addr[1]?1100:0011
  - word: wdata=sd, wstrb=1111
- Load extraction: byte lane k or half lane addr[1], then sign-extend, or zero-extend when mem_unsigned_in=1. Word loads pass through unchanged.
- Back-to-back memory ops: each costs a minimum of 2 cycles (IDLE→WAIT→IDLE), with a 0-wait ack on the first WAIT cycle.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no dmem request and raises no stall. Next cycle: valid_out=1, writeback_en_out=0, rd_out=faulting address, misalign_out=1 for exactly one cycle.
- Undefined: misalign_out is tied 0. The low address bits not needed for lane selection are ignored (half uses addr[1] only; word ignores addr[1:0]). The access proceeds normally.

Test Plan:
- Pass-through: valid_in=1, no mem op, rd_addr_in=5, rd_in=0x1234, wb_en=1 → next cycle valid_out=1, rd_addr_out=5, rd_out=0x1234, wb_en_out=1, stall_out never high.
- Signed byte load: addr=0x103, rdata=0x80FF_0000 with ack after 3 WAIT cycles → dmem_addr=0x100, req stable 3 cycles, rd_out=0xFFFF_FF80. Repeated with unsigned=1 → rd_out=0x0000_0080.
- Half store: addr=0x22, sd=0xABCD_1234 → dmem_we=1, wdata=0x1234_1234, wstrb=1100, writeback_en_out=0 on ack.
- Back-to-back load, load, non-mem op with 0-wait ack → each load produces exactly one valid_out. stall_out holds upstream correctly; the ALU op emerges the cycle after the second ack.
- Reset mid-WAIT: assert rst while dmem_req=1 → dmem_req=0 immediately, all outputs 0. A later ack produces no valid_out.
- With MEM_STAGE_MISALIGN_TRAP_EN: word load at 0x201 → no dmem_req, misalign_out=1 for one cycle, rd_out=0x201, writeback_en_out=0.
